// File: rtl/conv_window_tracker_pkg.sv
// Shared conv2d pipeline definitions: stride codes and the frame FSM encoding,
// also consumed by the line-buffer controller.
package conv_window_tracker_pkg;

  // Stride_Sel encodings: stride = code + 1
  localparam logic [1:0] STRIDE_1 = 2'd0;
  localparam logic [1:0] STRIDE_2 = 2'd1;
  localparam logic [1:0] STRIDE_3 = 2'd2;
  localparam logic [1:0] STRIDE_4 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/conv_window_tracker_if.sv
// Pixel-accept control and window-position outputs of conv_window_tracker.
interface conv_window_tracker_if #(
  parameter int DATA_WIDTH = 14
) ();

  logic                  Clr;
  logic                  En;
  logic [1:0]            Stride_Sel;
  logic [DATA_WIDTH-1:0] Col;
  logic [DATA_WIDTH-1:0] Row;
  logic [DATA_WIDTH-1:0] Out_X;
  logic [DATA_WIDTH-1:0] Out_Y;
  logic                  Win_Valid;
  logic                  Line_End;
  logic                  Frame_End;
  logic                  Busy;

  modport master (
    output Clr, En, Stride_Sel,
    input  Col, Row, Out_X, Out_Y, Win_Valid, Line_End, Frame_End, Busy
  );

  modport slave (
    input  Clr, En, Stride_Sel,
    output Col, Row, Out_X, Out_Y, Win_Valid, Line_End, Frame_End, Busy
  );

endinterface

// File: rtl/conv_window_tracker_win_axis_counter.sv
// One axis of the window tracker: 1-based position with wrap, stride phase
// (divider-free grid test) and the output-feature-map index along this axis.
module win_axis_counter
  import conv_window_tracker_pkg::*;
#(
  parameter int DATA_WIDTH  = 14,
  parameter int LIMIT       = 100,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Clr_i,
  input  logic                  Advance_i,
  input  logic                  Restart_i,
  input  logic                  Idx_Inc_i,
  input  logic [1:0]            Stride_i,
  output logic [DATA_WIDTH-1:0] Pos_o,
  output logic                  Phase_Zero_o,
  output logic                  Wrap_o,
  output logic                  At_Limit_o,
  output logic                  Idx_Empty_o,
  output logic [DATA_WIDTH-1:0] Out_Idx_o
);

  localparam logic [DATA_WIDTH-1:0] LIMIT_V = DATA_WIDTH'(LIMIT);
  localparam logic [DATA_WIDTH-1:0] K_V     = DATA_WIDTH'(KERNEL_SIZE);
  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] pos_q, pos_d;
  logic [1:0]            phase_q, phase_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] nidx_q, nidx_d;
  logic                  step;
  logic                  start;

  always_comb begin
    step    = Advance_i | Restart_i;
    pos_d   = pos_q;
    phase_d = phase_q;
    Wrap_o  = 1'b0;

    if (Restart_i) begin
      pos_d = ONE;
    end else if (Advance_i) begin
      if (pos_q == LIMIT_V) begin
        pos_d  = ONE;
        Wrap_o = 1'b1;
      end else begin
        pos_d = pos_q + ONE;
      end
    end

    // Phase is pinned to 0 up to and including K, then counts modulo the stride,
    // so phase 0 past K marks (pos-K) mod S == 0.
    if (step) begin
      if (pos_d <= K_V) begin
        phase_d = '0;
      end else if (phase_q == Stride_i) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end

    start        = step && (pos_d == ONE);
    Phase_Zero_o = (pos_d >= K_V) && (phase_d == '0);
    At_Limit_o   = (pos_d == LIMIT_V);
    Idx_Empty_o  = start || (nidx_q == '0);

    // out holds the index of the most recent window; nidx is the index the next one gets.
    out_d  = out_q;
    nidx_d = nidx_q;
    if (start) begin
      out_d  = '0;
      nidx_d = Idx_Inc_i ? ONE : '0;
    end else if (Idx_Inc_i) begin
      out_d  = nidx_q;
      nidx_d = nidx_q + ONE;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pos_q   <= '0;
      phase_q <= '0;
      out_q   <= '0;
      nidx_q  <= '0;
    end else if (Clr_i) begin
      pos_q   <= '0;
      phase_q <= '0;
      out_q   <= '0;
      nidx_q  <= '0;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      nidx_q  <= nidx_d;
    end
  end

  assign Pos_o     = pos_q;
  assign Out_Idx_o = out_q;

endmodule

// File: rtl/conv_window_tracker.sv
// Raster-scan position tracker for the conv2d pipeline: flags pixels that close a
// strided KERNEL_SIZE x KERNEL_SIZE window and reports output-map coordinates.
module conv_window_tracker
  import conv_window_tracker_pkg::*;
#(
  parameter int DATA_WIDTH  = 14,
  parameter int IMG_WIDTH   = 100,
  parameter int IMG_HEIGHT  = 100,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                   Clk,
  input  logic                   Rst,
  conv_window_tracker_if.slave   bus
);

  state_e     state_q;
  logic [1:0] stride_q;
  logic       win_q, line_end_q, frame_end_q, busy_q;

  logic                  accept, first, col_adv;
  logic                  win, line_end, frame_end;
  logic [DATA_WIDTH-1:0] col_pos, row_pos, col_idx, row_idx;
  logic                  col_pz, col_wrap, col_at_lim, col_empty;
  logic                  row_pz, row_at_lim;
  logic                  unused_row_wrap, unused_row_empty;

  always_comb begin
    accept    = bus.En & ~bus.Clr;
    first     = accept && (state_q == ST_IDLE);
    col_adv   = accept && (state_q == ST_RUN);
    win       = accept & col_pz & row_pz;
    line_end  = accept & col_at_lim;
    frame_end = line_end & row_at_lim;
  end

  win_axis_counter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LIMIT       (IMG_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_col (
    .Clk          (Clk),
    .Rst          (Rst),
    .Clr_i        (bus.Clr),
    .Advance_i    (col_adv),
    .Restart_i    (first),
    .Idx_Inc_i    (win),
    .Stride_i     (stride_q),
    .Pos_o        (col_pos),
    .Phase_Zero_o (col_pz),
    .Wrap_o       (col_wrap),
    .At_Limit_o   (col_at_lim),
    .Idx_Empty_o  (col_empty),
    .Out_Idx_o    (col_idx)
  );

  // The row index advances only on the first window of a row.
  win_axis_counter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LIMIT       (IMG_HEIGHT),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_row (
    .Clk          (Clk),
    .Rst          (Rst),
    .Clr_i        (bus.Clr),
    .Advance_i    (col_wrap),
    .Restart_i    (first),
    .Idx_Inc_i    (win & col_empty),
    .Stride_i     (stride_q),
    .Pos_o        (row_pos),
    .Phase_Zero_o (row_pz),
    .Wrap_o       (unused_row_wrap),
    .At_Limit_o   (row_at_lim),
    .Idx_Empty_o  (unused_row_empty),
    .Out_Idx_o    (row_idx)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_IDLE;
      stride_q    <= STRIDE_1;
      win_q       <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.Clr) begin
      state_q     <= ST_IDLE;
      stride_q    <= STRIDE_1;
      win_q       <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      win_q       <= win;
      line_end_q  <= line_end;
      frame_end_q <= frame_end;
      if (accept) begin
        if (first) begin
          stride_q <= bus.Stride_Sel;
        end
        // A frame-closing pixel returns to IDLE so the next En restarts at (1,1).
        state_q <= frame_end ? ST_IDLE : ST_RUN;
        busy_q  <= ~frame_end;
      end
    end
  end

  assign bus.Col       = col_pos;
  assign bus.Row       = row_pos;
  assign bus.Out_X     = col_idx;
  assign bus.Out_Y     = row_idx;
  assign bus.Win_Valid = win_q;
  assign bus.Line_End  = line_end_q;
  assign bus.Frame_End = frame_end_q;
  assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_conv_window_tracker.sv
// Directed bench for conv_window_tracker on a 6x5 image with a 3x3 kernel.
module tb_conv_window_tracker;

  localparam int DW = 14;
  localparam int W  = 6;
  localparam int H  = 5;
  localparam int K  = 3;

  typedef struct {
    logic [1:0] ss;
    int         row;
    int         col;
    int         ox;
    int         oy;
  } win_t;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  conv_window_tracker_if #(.DATA_WIDTH(DW)) bus ();

  conv_window_tracker #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (K)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  win_t tbl [18];
  int n_chk  = 0;
  int n_pass = 0;
  int m_col, m_row, m_ox, m_oy;
  logic m_busy;
  int n_win, n_le, n_fe;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int find_win(input logic [1:0] ss, input int r, input int c);
    for (int i = 0; i < 18; i++)
      if (tbl[i].ss == ss && tbl[i].row == r && tbl[i].col == c) return i;
    return -1;
  endfunction

  task automatic check_all(input string tag, input logic e_win, input logic e_le, input logic e_fe);
    chk($sformatf("Col %s", tag), bus.Col, m_col);
    chk($sformatf("Row %s", tag), bus.Row, m_row);
    chk($sformatf("Win_Valid %s", tag), bus.Win_Valid, e_win);
    chk($sformatf("Out_X %s", tag), bus.Out_X, m_ox);
    chk($sformatf("Out_Y %s", tag), bus.Out_Y, m_oy);
    chk($sformatf("Line_End %s", tag), bus.Line_End, e_le);
    chk($sformatf("Frame_End %s", tag), bus.Frame_End, e_fe);
    chk($sformatf("Busy %s", tag), bus.Busy, m_busy);
  endtask

  task automatic pixel(input logic [1:0] ss, input logic [1:0] drive_ss, input int r, input int c);
    int idx;
    logic e_le, e_fe;
    bus.En = 1'b1;
    bus.Clr = 1'b0;
    bus.Stride_Sel = drive_ss;
    @(posedge Clk); #1;
    bus.En = 1'b0;
    idx = find_win(ss, r, c);
    if (c == 1) m_ox = 0;
    if (r == 1 && c == 1) m_oy = 0;
    if (idx >= 0) begin
      m_ox = tbl[idx].ox;
      m_oy = tbl[idx].oy;
    end
    m_col = c;
    m_row = r;
    e_le = (c == W);
    e_fe = (c == W) && (r == H);
    m_busy = ~e_fe;
    check_all($sformatf("px(%0d,%0d) s%0d", r, c, ss), idx >= 0, e_le, e_fe);
    if (bus.Win_Valid) n_win++;
    if (bus.Line_End) n_le++;
    if (bus.Frame_End) n_fe++;
  endtask

  task automatic gap(input logic [1:0] drive_ss);
    bus.En = 1'b0;
    bus.Clr = 1'b0;
    bus.Stride_Sel = drive_ss;
    @(posedge Clk); #1;
    check_all($sformatf("gap(%0d,%0d)", m_row, m_col), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input logic [1:0] ss, input bit gaps, input bit toggle, input int exp_wins);
    n_win = 0; n_le = 0; n_fe = 0;
    for (int p = 0; p < W * H; p++) begin
      if (gaps && p > 0) repeat ($urandom_range(0, 2)) gap(2'($urandom_range(0, 3)));
      pixel(ss, (toggle && p > 0) ? 2'($urandom_range(0, 3)) : ss, p / W + 1, p % W + 1);
    end
    chk($sformatf("window count s%0d", ss), n_win, exp_wins);
    chk($sformatf("line_end count s%0d", ss), n_le, H);
    chk($sformatf("frame_end count s%0d", ss), n_fe, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Stride 1: every (row,col) with row,col >= 3
    tbl[0]  = '{2'd0, 3, 3, 0, 0};  tbl[1]  = '{2'd0, 3, 4, 1, 0};
    tbl[2]  = '{2'd0, 3, 5, 2, 0};  tbl[3]  = '{2'd0, 3, 6, 3, 0};
    tbl[4]  = '{2'd0, 4, 3, 0, 1};  tbl[5]  = '{2'd0, 4, 4, 1, 1};
    tbl[6]  = '{2'd0, 4, 5, 2, 1};  tbl[7]  = '{2'd0, 4, 6, 3, 1};
    tbl[8]  = '{2'd0, 5, 3, 0, 2};  tbl[9]  = '{2'd0, 5, 4, 1, 2};
    tbl[10] = '{2'd0, 5, 5, 2, 2};  tbl[11] = '{2'd0, 5, 6, 3, 2};
    // Stride 2
    tbl[12] = '{2'd1, 3, 3, 0, 0};  tbl[13] = '{2'd1, 3, 5, 1, 0};
    tbl[14] = '{2'd1, 5, 3, 0, 1};  tbl[15] = '{2'd1, 5, 5, 1, 1};
    // Stride 3
    tbl[16] = '{2'd2, 3, 3, 0, 0};  tbl[17] = '{2'd2, 3, 6, 1, 0};

    bus.En = 1'b0;
    bus.Clr = 1'b0;
    bus.Stride_Sel = 2'd0;
    m_col = 0; m_row = 0; m_ox = 0; m_oy = 0; m_busy = 1'b0;

    #12;
    check_all("reset", 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check_all("after reset idle", 1'b0, 1'b0, 1'b0);

    run_frame(2'd0, 1'b0, 1'b0, 12);
    run_frame(2'd1, 1'b0, 1'b0, 4);
    run_frame(2'd2, 1'b0, 1'b1, 2);
    run_frame(2'd0, 1'b1, 1'b0, 12);
    // Back-to-back frames: second frame's first pixel must read (1,1)
    run_frame(2'd0, 1'b0, 1'b0, 12);
    run_frame(2'd0, 1'b0, 1'b0, 12);

    // Clr together with En on pixel (2,4)
    for (int p = 0; p < 9; p++) pixel(2'd0, 2'd0, p / W + 1, p % W + 1);
    bus.En = 1'b1;
    bus.Clr = 1'b1;
    @(posedge Clk); #1;
    bus.En = 1'b0;
    bus.Clr = 1'b0;
    m_col = 0; m_row = 0; m_ox = 0; m_oy = 0; m_busy = 1'b0;
    check_all("clr with en", 1'b0, 1'b0, 1'b0);
    gap(2'd0);
    run_frame(2'd0, 1'b0, 1'b0, 12);

    // Asynchronous reset mid-row 4
    for (int p = 0; p < 21; p++) pixel(2'd1, 2'd1, p / W + 1, p % W + 1);
    #2 Rst = 1'b0;
    #1;
    m_col = 0; m_row = 0; m_ox = 0; m_oy = 0; m_busy = 1'b0;
    check_all("async reset", 1'b0, 1'b0, 1'b0);
    #2 Rst = 1'b1;
    run_frame(2'd2, 1'b0, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
